// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl -- load-use stall, taken-branch flush and EX operand forwarding control.
// Rev 1.0
`default_nettype none

module ex_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ID_VALID,
  input  logic [4:0]       RS1_ID,
  input  logic [4:0]       RS2_ID,
  input  logic             USES_RS1_ID,
  input  logic             USES_RS2_ID,
  input  logic [4:0]       RD_ID,
  input  logic             RegWrite_ID,
  input  logic             MemRead_ID,
  input  logic             BRANCH_TAKEN_MEM,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             PC_WRITE,
  output logic             IF_ID_WRITE,
  output logic             ID_EX_BUBBLE,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             EX_MEM_FLUSH,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;

  logic             r_ex_valid, r_ex_rw, r_ex_mr;
  logic [4:0]       r_ex_rd;
  logic             r_mem_valid, r_mem_rw, r_mem_mr;
  logic [4:0]       r_mem_rd;
  logic             r_wb_valid, r_wb_rw, r_wb_mr;
  logic [4:0]       r_wb_rd;

  logic [1:0]       r_fwd_a, r_fwd_b;
  logic [1:0]       w_fwd_a, w_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic             w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2;
  logic             w_load_use, w_stall, w_flush, w_enter;
  logic             w_unused_wb;

  function automatic logic slot_match(input logic valid, input logic rw,
                                      input logic [4:0] rd, input logic [4:0] rs,
                                      input logic uses);
    return valid && rw && (rd != 5'd0) && (rd == rs) && uses;
  endfunction

  assign w_ex_m1  = slot_match(r_ex_valid,  r_ex_rw,  r_ex_rd,  RS1_ID, USES_RS1_ID);
  assign w_ex_m2  = slot_match(r_ex_valid,  r_ex_rw,  r_ex_rd,  RS2_ID, USES_RS2_ID);
  assign w_mem_m1 = slot_match(r_mem_valid, r_mem_rw, r_mem_rd, RS1_ID, USES_RS1_ID);
  assign w_mem_m2 = slot_match(r_mem_valid, r_mem_rw, r_mem_rd, RS2_ID, USES_RS2_ID);

  // WB slot is tracked for completeness; the register file is write-before-read so nothing forwards from it.
  assign w_unused_wb = ^{r_wb_valid, r_wb_rw, r_wb_mr, r_wb_rd};

  assign w_load_use = ID_VALID && r_ex_mr && (w_ex_m1 || w_ex_m2);
  assign w_flush    = BRANCH_TAKEN_MEM && reset_n;
  assign w_enter    = ID_VALID && !w_stall && !w_flush;

  always_comb begin
    w_fwd_a = FWD_RF;
    if (w_ex_m1)       w_fwd_a = FWD_MEM;
    else if (w_mem_m1) w_fwd_a = FWD_WB;
    w_fwd_b = FWD_RF;
    if (w_ex_m2)       w_fwd_b = FWD_MEM;
    else if (w_mem_m2) w_fwd_b = FWD_WB;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_RUN;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a flush suppresses the stall and so always lands in RUN.
  always_comb begin
    w_state_nxt = S_RUN;
    case (r_state)
      S_RUN:   w_state_nxt = w_stall ? S_STALL : S_RUN;
      S_STALL: w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // Output logic; in STALL the EX slot is invalid so the re-evaluated hazard cannot fire.
  always_comb begin
    w_stall      = 1'b0;
    case (r_state)
      S_RUN:   w_stall = w_load_use && !w_flush;
      S_STALL: w_stall = w_load_use && !w_flush;
      default: w_stall = 1'b0;
    endcase
    PC_WRITE     = !w_stall;
    IF_ID_WRITE  = !w_stall;
    ID_EX_BUBBLE = w_stall;
    IF_ID_FLUSH  = w_flush;
    ID_EX_FLUSH  = w_flush;
    EX_MEM_FLUSH = w_flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_rw     <= 1'b0;
      r_ex_mr     <= 1'b0;
      r_ex_rd     <= 5'd0;
      r_mem_valid <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_mr    <= 1'b0;
      r_mem_rd    <= 5'd0;
      r_wb_valid  <= 1'b0;
      r_wb_rw     <= 1'b0;
      r_wb_mr     <= 1'b0;
      r_wb_rd     <= 5'd0;
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wb_valid  <= r_mem_valid;
      r_wb_rw     <= r_mem_rw;
      r_wb_mr     <= r_mem_mr;
      r_wb_rd     <= r_mem_rd;
      r_mem_valid <= r_ex_valid && !w_flush;
      r_mem_rw    <= r_ex_rw;
      r_mem_mr    <= r_ex_mr;
      r_mem_rd    <= r_ex_rd;
      r_ex_valid  <= w_enter;
      r_ex_rw     <= RegWrite_ID;
      r_ex_mr     <= MemRead_ID;
      r_ex_rd     <= RD_ID;
      r_fwd_a     <= w_enter ? w_fwd_a : FWD_RF;
      r_fwd_b     <= w_enter ? w_fwd_b : FWD_RF;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign forwardA  = r_fwd_a;
  assign forwardB  = r_fwd_b;
  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;

endmodule

`default_nettype wire
